// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory path: funct3 encodings, access sizes,
// the load/store sequencer state type and request legality helpers.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } lsu_state_t;

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!is_store)
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

  function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SZ_HALF) && addr_lo[0]) || ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load data extension: selects the low byte/half of the raw memory word and
// sign- or zero-extends it according to the load funct3.
module load_extend
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw_data,
  output logic [31:0] ext_data
);

  always_comb begin
    ext_data = raw_data;
    case (funct3)
      F3_B:    ext_data = {{24{raw_data[7]}}, raw_data[7:0]};
      F3_H:    ext_data = {{16{raw_data[15]}}, raw_data[15:0]};
      F3_BU:   ext_data = {24'd0, raw_data[7:0]};
      F3_HU:   ext_data = {16'd0, raw_data[15:0]};
      default: ext_data = raw_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store sequencer between execute and a 1-cycle
// synchronous data memory; faults illegal or misaligned requests without access.
//
// state   | meaning
// IDLE    | ready for a request; req_ready high
// ISSUE   | address/size/data on the memory port, write strobe for stores
// CAPTURE | memory read data valid; extend and load the response
// RESP    | response held until writeback accepts it
module load_store_unit
  import riscv_mem_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b0,
  parameter int XLEN             = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic [4:0]      resp_rd,
  output logic            resp_fault,
  output logic            mem_read_write,
  output logic [XLEN-1:0] mem_address,
  output logic [1:0]      mem_access_size,
  output logic [XLEN-1:0] mem_data_in,
  input  logic [XLEN-1:0] mem_data_out
);

  lsu_state_t  state;
  logic        lat_write;
  logic [2:0]  lat_funct3;
  logic [4:0]  lat_rd;
  logic [31:0] ext_data;
  logic        req_fault;

  assign req_ready = (state == IDLE);

  assign req_fault = !f3_legal(req_write, req_funct3) ||
                     (!ALLOW_MISALIGNED && addr_misaligned(req_funct3[1:0], req_addr[1:0]));

  load_extend u_load_extend (
    .funct3   (lat_funct3),
    .raw_data (mem_data_out),
    .ext_data (ext_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      lat_write       <= 1'b0;
      lat_funct3      <= 3'd0;
      lat_rd          <= 5'd0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_rd         <= 5'd0;
      resp_fault      <= 1'b0;
      mem_read_write  <= 1'b0;
      mem_address     <= '0;
      mem_access_size <= SZ_BYTE;
      mem_data_in     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write  <= req_write;
            lat_funct3 <= req_funct3;
            lat_rd     <= req_rd;
            if (req_fault) begin
              // Faults bypass the memory entirely so no side effect can occur.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= '0;
              resp_rd    <= 5'd0;
            end else begin
              state           <= ISSUE;
              mem_address     <= req_addr;
              mem_access_size <= req_funct3[1:0];
              mem_read_write  <= req_write;
              mem_data_in     <= req_wdata;
            end
          end
        end
        ISSUE: begin
          mem_read_write <= 1'b0;
          state          <= CAPTURE;
        end
        CAPTURE: begin
          resp_valid <= 1'b1;
          resp_fault <= 1'b0;
          resp_rdata <= lat_write ? '0 : ext_data;
          resp_rd    <= lat_write ? 5'd0 : lat_rd;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
